// File: rtl/ysyx_23060201_inst_queue_pkg.sv
// Shared sizing defaults and pointer-width helper for the fetch->decode instruction queue.
package ysyx_23060201_inst_queue_pkg;

  localparam int IQ_ADDR_W = 32;
  localparam int IQ_DATA_W = 32;
  localparam int IQ_DEPTH  = 4;

  // Pointers carry one extra wrap bit above the index.
  function automatic int iq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ysyx_23060201_iq_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port, no reset.
// Contents are undefined until written; the top masks reads while empty.
module ysyx_23060201_iq_ram
  import ysyx_23060201_inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int WIDTH = IQ_ADDR_W + IQ_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_23060201_inst_queue.sv
// Circular {pc,inst} queue between fetch and decode; 1-cycle latency, in_ready = !full from state only.
// INST_QUEUE_BYPASS_EN adds a combinational pass-through when the queue is empty.
module ysyx_23060201_inst_queue
  import ysyx_23060201_inst_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = IQ_ADDR_W,
  parameter int DATA_WIDTH = IQ_DATA_W,
  parameter int DEPTH      = IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]    out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = iq_ptr_w(DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          bypass_take;
  logic [EW-1:0] rd_entry;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign in_ready = !full;
  assign count    = wr_ptr - rd_ptr;

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass_on;
  // Gated by rst so the pass-through stays quiet while reset is held.
  assign bypass_on   = empty && !flush && rst;
  assign bypass_take = bypass_on && in_valid && out_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = in_valid && in_ready && !flush && !bypass_take;
  assign pop  = !empty && out_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  ysyx_23060201_iq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[IW-1:0]),
    .wdata ({in_pc, in_inst}),
    .raddr (rd_ptr[IW-1:0]),
    .rdata (rd_entry)
  );

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_inst  = '0;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = rd_entry[EW-1:DATA_WIDTH];
      out_inst  = rd_entry[DATA_WIDTH-1:0];
    end
`ifdef INST_QUEUE_BYPASS_EN
    else if (bypass_on) begin
      out_valid = in_valid;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end
`endif
  end

endmodule

// File: tb/tb_ysyx_23060201_inst_queue.sv
// Directed bench for the instruction queue with a queue-based reference model checked every negedge.
module tb_ysyx_23060201_inst_queue;

`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mq [$];
  logic [31:0] recv [$];
  logic [31:0] insts [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

  ysyx_23060201_inst_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered list of stored {pc,inst} pairs.
  always @(negedge rst) mq.delete();

  always @(posedge clk) begin : model
    int sz;
    if (rst) begin
      sz = mq.size();
      if (flush) begin
        mq.delete();
      end else if (!(BYP && sz == 0 && in_valid && out_ready)) begin
        if (sz > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && sz < DEPTH) mq.push_back({in_pc, in_inst});
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    int          sz;
    sz  = mq.size();
    ev  = 1'b0;
    epc = '0;
    ein = '0;
    if (rst && sz > 0) begin
      ev  = 1'b1;
      epc = mq[0][63:32];
      ein = mq[0][31:0];
    end else if (rst && BYP && in_valid && !flush) begin
      ev  = 1'b1;
      epc = in_pc;
      ein = in_inst;
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_pc",    64'(out_pc),    64'(epc));
    chk("out_inst",  64'(out_inst),  64'(ein));
    chk("count",     64'(count),     rst ? 64'(sz) : 64'd0);
    chk("in_ready",  64'(in_ready),  (!rst || sz < DEPTH) ? 64'd1 : 64'd0);
    if (rst && out_valid && out_ready && !flush) recv.push_back(out_pc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    // 1. reset
    repeat (2) cyc();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    rst = 1'b1;
    cyc();

    // 2. fill then drain
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = MB + 32'(4 * k); in_inst = insts[k];
      cyc();
    end
    in_valid = 1'b0;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", 64'(out_pc), 64'(MB + 32'(4 * k)));
      chk("drain_inst", 64'(out_inst), 64'(insts[k]));
      chk("drain_count", 64'(count), 64'(4 - k));
      cyc();
    end
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_valid", 64'(out_valid), 64'd0);

    // 3. stream across pointer wrap
    recv.delete();
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1; in_pc = MB + 32'(4 * k); in_inst = 32'(k);
      cyc();
      if (k > 0) chk("stream_count", 64'(count), BYP ? 64'd0 : 64'd1);
    end
    in_valid = 1'b0;
    repeat (2) cyc();
    chk("stream_recv_n", 64'(recv.size()), 64'd12);
    for (int k = 0; k < 12 && k < recv.size(); k++)
      chk("stream_order", 64'(recv[k]), 64'(MB + 32'(4 * k)));
    out_ready = 1'b0;

    // 4. full with simultaneous pop: no push that cycle
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = MB + 32'h40 + 32'(4 * k); in_inst = 32'(k);
      cyc();
    end
    in_pc = MB + 32'h50; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_head", 64'(out_pc), 64'(MB + 32'h44));

    // 5. flush overrides push and pop
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = MB + 32'h60;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_pc = MB + 32'h100; in_inst = 32'h13;
    cyc();
    in_valid = 1'b0;
    chk("postflush_valid", 64'(out_valid), 64'd1);
    chk("postflush_pc", 64'(out_pc), 64'(MB + 32'h100));
    flush = 1'b1;
    repeat (2) cyc();
    flush = 1'b0;
    chk("flush_empty_count", 64'(count), 64'd0);

    // 6. async reset between edges
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_pc = MB + 32'h200 + 32'(4 * k); in_inst = 32'(k);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_arst_count", 64'(count), 64'd2);
    #2;
    rst = 1'b0;
    in_valid = 1'b1; in_pc = MB + 32'h300;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("post_arst_valid", 64'(out_valid), 64'd0);
    chk("post_arst_count", 64'(count), 64'd0);
    in_valid = 1'b1; in_pc = MB + 32'h400; in_inst = 32'h13;
    cyc();
    in_valid = 1'b0;
    chk("post_arst_push", 64'(out_pc), 64'(MB + 32'h400));
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
